// File: rtl/vga_timing_pkg.sv
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Default 640x480@60 timing constants, control-flag struct and
//                colour-expansion values shared by the VGA timing path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int c_H_VISIBLE_DEF  = 640;
    localparam int c_H_FRONT_DEF    = 16;
    localparam int c_H_SYNC_DEF     = 96;
    localparam int c_H_BACK_DEF     = 48;
    localparam int c_V_VISIBLE_DEF  = 480;
    localparam int c_V_FRONT_DEF    = 10;
    localparam int c_V_SYNC_DEF     = 2;
    localparam int c_V_BACK_DEF     = 33;
    localparam int c_PIPE_DELAY_DEF = 2;

    localparam int c_H_TOTAL_DEF = c_H_VISIBLE_DEF + c_H_FRONT_DEF + c_H_SYNC_DEF + c_H_BACK_DEF;
    localparam int c_V_TOTAL_DEF = c_V_VISIBLE_DEF + c_V_FRONT_DEF + c_V_SYNC_DEF + c_V_BACK_DEF;

    localparam int c_CNT_W = 10;

    localparam logic [1:0] c_COLOUR_WHITE = 2'b11;
    localparam logic [1:0] c_COLOUR_BLACK = 2'b00;

    // Per-pixel control flags that travel alongside the frame-buffer latency.
    typedef struct packed {
        logic de;
        logic hs_n;
        logic vs_n;
    } sync_flags_t;

    localparam sync_flags_t c_FLAGS_IDLE = '{de: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

endpackage

`default_nettype wire

// File: rtl/sync_delay_line.sv
// ============================================================================
//  Module      : sync_delay_line
//  Description : WIDTH x DEPTH shift register with a reset fill value;
//                DEPTH = 0 is a straight wire.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rst_val_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused_bypass;
            assign w_unused_bypass = &{1'b0, clk, reset, rst_val_i};
            assign q_o = d_i;
        end else begin : g_stages
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= rst_val_i;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_generator.sv
// ============================================================================
//  Module      : vga_timing_generator
//  Description : VGA raster counters, latency-matched sync/RGB pin drive and
//                vblank / frame_start indications for the game logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = c_H_VISIBLE_DEF,
    parameter int H_FRONT    = c_H_FRONT_DEF,
    parameter int H_SYNC     = c_H_SYNC_DEF,
    parameter int H_BACK     = c_H_BACK_DEF,
    parameter int V_VISIBLE  = c_V_VISIBLE_DEF,
    parameter int V_FRONT    = c_V_FRONT_DEF,
    parameter int V_SYNC     = c_V_SYNC_DEF,
    parameter int V_BACK     = c_V_BACK_DEF,
    parameter int PIPE_DELAY = c_PIPE_DELAY_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               colour,
    output logic [c_CNT_W-1:0] counter_H,
    output logic [c_CNT_W-1:0] counter_V,
    output logic               hsync,
    output logic               vsync,
    output logic [1:0]         red,
    output logic [1:0]         green,
    output logic [1:0]         blue,
    output logic               vblank,
    output logic               frame_start
);

    localparam logic [c_CNT_W-1:0] c_H_LAST     = c_CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [c_CNT_W-1:0] c_V_LAST     = c_CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [c_CNT_W-1:0] c_H_VIS      = c_CNT_W'(H_VISIBLE);
    localparam logic [c_CNT_W-1:0] c_V_VIS      = c_CNT_W'(V_VISIBLE);
    localparam logic [c_CNT_W-1:0] c_HS_FIRST   = c_CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [c_CNT_W-1:0] c_HS_LAST    = c_CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [c_CNT_W-1:0] c_VS_FIRST   = c_CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [c_CNT_W-1:0] c_VS_LAST    = c_CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [c_CNT_W-1:0] counter_H_q, counter_H_d;
    logic [c_CNT_W-1:0] counter_V_q, counter_V_d;
    logic               hsync_q, vsync_q;
    logic [1:0]         pix_q, pix_d;
    logic               frame_start_q, frame_start_d;

    sync_flags_t        w_flags;
    sync_flags_t        w_flags_dly;

    always_comb begin
        counter_H_d = counter_H_q + 1'b1;
        counter_V_d = counter_V_q;
        if (counter_H_q == c_H_LAST) begin
            counter_H_d = '0;
            counter_V_d = (counter_V_q == c_V_LAST) ? '0 : counter_V_q + 1'b1;
        end
    end

    always_comb begin
        w_flags.de   = (counter_H_q < c_H_VIS) && (counter_V_q < c_V_VIS);
        w_flags.hs_n = !((counter_H_q >= c_HS_FIRST) && (counter_H_q <= c_HS_LAST));
        w_flags.vs_n = !((counter_V_q >= c_VS_FIRST) && (counter_V_q <= c_VS_LAST));
    end

    // Flags wait here while the frame buffer fetches the matching pixel.
    sync_delay_line #(
        .WIDTH ($bits(sync_flags_t)),
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay_line (
        .clk       (clk),
        .reset     (reset),
        .rst_val_i (c_FLAGS_IDLE),
        .d_i       (w_flags),
        .q_o       (w_flags_dly)
    );

    always_comb begin
        pix_d = c_COLOUR_BLACK;
        if (w_flags_dly.de && colour) begin
            pix_d = c_COLOUR_WHITE;
        end
        frame_start_d = (counter_H_d == '0) && (counter_V_d == c_V_VIS);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            counter_H_q   <= '0;
            counter_V_q   <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            pix_q         <= c_COLOUR_BLACK;
            frame_start_q <= 1'b0;
        end else begin
            counter_H_q   <= counter_H_d;
            counter_V_q   <= counter_V_d;
            hsync_q       <= w_flags_dly.hs_n;
            vsync_q       <= w_flags_dly.vs_n;
            pix_q         <= pix_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign counter_H   = counter_H_q;
    assign counter_V   = counter_V_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = pix_q;
    assign green       = pix_q;
    assign blue        = pix_q;
    // Taken from the live counters so game logic sees blanking ahead of the pins.
    assign vblank      = (counter_V_q >= c_V_VIS);
    assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
// ============================================================================
//  Module      : tb_vga_timing_generator
//  Description : Scoreboard bench: one default-timing DUT plus three reduced
//                timing DUTs with PIPE_DELAY 0, 2 and 4.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing_generator;

    localparam int NI = 4;
    localparam int T_HV [NI] = '{640, 16, 16, 16};
    localparam int T_HF [NI] = '{16, 4, 4, 4};
    localparam int T_HS [NI] = '{96, 6, 6, 6};
    localparam int T_HB [NI] = '{48, 4, 4, 4};
    localparam int T_VV [NI] = '{480, 8, 8, 8};
    localparam int T_VF [NI] = '{10, 2, 2, 2};
    localparam int T_VS [NI] = '{2, 2, 2, 2};
    localparam int T_VB [NI] = '{33, 3, 3, 3};
    localparam int T_PD [NI] = '{2, 0, 2, 4};

    typedef struct {
        int          inst;
        int          n;
        logic [29:0] v;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [NI-1:0] col;
    logic          mode;
    int            phase;
    int            n;
    int            tests = 0;
    int            fails = 0;
    int            lows = 0;
    int            last_fs = -1;
    exp_t          sb_q [$];

    wire [9:0]     cH [NI];
    wire [9:0]     cV [NI];
    wire [1:0]     rd [NI];
    wire [1:0]     gr [NI];
    wire [1:0]     bl [NI];
    wire [NI-1:0]  hs, vs, vb, fs;

    always #5 clk = ~clk;

    vga_timing_generator dut0 (
        .clk(clk), .reset(reset), .colour(col[0]),
        .counter_H(cH[0]), .counter_V(cV[0]), .hsync(hs[0]), .vsync(vs[0]),
        .red(rd[0]), .green(gr[0]), .blue(bl[0]), .vblank(vb[0]), .frame_start(fs[0])
    );

    vga_timing_generator #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(0)
    ) dut1 (
        .clk(clk), .reset(reset), .colour(col[1]),
        .counter_H(cH[1]), .counter_V(cV[1]), .hsync(hs[1]), .vsync(vs[1]),
        .red(rd[1]), .green(gr[1]), .blue(bl[1]), .vblank(vb[1]), .frame_start(fs[1])
    );

    vga_timing_generator #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(2)
    ) dut2 (
        .clk(clk), .reset(reset), .colour(col[2]),
        .counter_H(cH[2]), .counter_V(cV[2]), .hsync(hs[2]), .vsync(vs[2]),
        .red(rd[2]), .green(gr[2]), .blue(bl[2]), .vblank(vb[2]), .frame_start(fs[2])
    );

    vga_timing_generator #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(4)
    ) dut3 (
        .clk(clk), .reset(reset), .colour(col[3]),
        .counter_H(cH[3]), .counter_V(cV[3]), .hsync(hs[3]), .vsync(vs[3]),
        .red(rd[3]), .green(gr[3]), .blue(bl[3]), .vblank(vb[3]), .frame_start(fs[3])
    );

    // Expected {H, V, hsync, vsync, vblank, frame_start, rgb} for cycle n,
    // where c is the colour the bench drove during cycle n-1.
    function automatic logic [29:0] model(input int i, input int cyc, input logic c);
        int ht, vt, h, v, k, hk, vk;
        logic hs_e, vs_e, de, vb_e, fs_e;
        logic [5:0] rgb;
        ht = T_HV[i] + T_HF[i] + T_HS[i] + T_HB[i];
        vt = T_VV[i] + T_VF[i] + T_VS[i] + T_VB[i];
        h = cyc % ht;
        v = (cyc / ht) % vt;
        hs_e = 1'b1;
        vs_e = 1'b1;
        rgb  = 6'd0;
        k = cyc - T_PD[i] - 1;
        if (k >= 0) begin
            hk = k % ht;
            vk = (k / ht) % vt;
            hs_e = !(hk >= T_HV[i] + T_HF[i] && hk < T_HV[i] + T_HF[i] + T_HS[i]);
            vs_e = !(vk >= T_VV[i] + T_VF[i] && vk < T_VV[i] + T_VF[i] + T_VS[i]);
            de   = (hk < T_HV[i]) && (vk < T_VV[i]);
            if (de && c) rgb = 6'h3f;
        end
        vb_e = (v >= T_VV[i]);
        fs_e = (h == 0) && (v == T_VV[i]);
        return {h[9:0], v[9:0], hs_e, vs_e, vb_e, fs_e, rgb};
    endfunction

    // Frame-buffer stand-in: pixel colour is H[0] of the counters PIPE_DELAY ago.
    function automatic logic drive_col(input int i, input int cyc, input logic m);
        int ht, j;
        ht = T_HV[i] + T_HF[i] + T_HS[i] + T_HB[i];
        j = cyc - T_PD[i];
        if (m) return 1'b1;
        if (j < 0) return 1'b0;
        return ((j % ht) % 2) == 1;
    endfunction

    function automatic logic [29:0] act_of(input int i);
        return {cH[i], cV[i], hs[i], vs[i], vb[i], fs[i], rd[i], gr[i], bl[i]};
    endfunction

    function automatic int rgb_of(input int i);
        return int'({rd[i], gr[i], bl[i]});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (n=%0d phase=%0d)", name, act, exp, n, phase);
        end
    endtask

    task automatic step();
        exp_t e;
        if (!reset) n = 0;
        else        n = n + 1;
        if (phase == 0 && n >= 4500) mode = 1'b1;
        for (int i = 0; i < NI; i++) begin
            e.inst = i;
            e.n    = n;
            e.v    = model(i, n, col[i]);
            sb_q.push_back(e);
            col[i] = drive_col(i, n, mode);
        end
    endtask

    initial begin
        reset = 1'b0;
        mode  = 1'b0;
        phase = 0;
        n     = 0;
        col   = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1; step();
        end
        reset = 1'b1;
        while (n < 9500) begin
            @(posedge clk); #1; step();
        end
        // Counters of dut0 read (700, 11): inside hsync.
        reset = 1'b0;
        @(posedge clk); #1;
        phase = 1;
        step();
        reset = 1'b1;
        for (int c = 0; c < 900; c++) begin
            @(posedge clk); #1; step();
        end
        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            tests++;
            if (act_of(e.inst) !== e.v) begin
                fails++;
                $display("FAIL sb_inst%0d n=%0d: got %h, expected %h", e.inst, e.n, act_of(e.inst), e.v);
            end
        end

        if (phase == 0) begin
            if (n == 0) begin
                chk("rst_H", int'(cH[0]), 0);
                chk("rst_V", int'(cV[0]), 0);
                chk("rst_hsync", int'(hs[0]), 1);
                chk("rst_vsync", int'(vs[0]), 1);
                chk("rst_rgb", rgb_of(0), 0);
            end
            if (n >= 1 && n <= 3) chk("cnt_after_rst", int'(cH[0]), n);
            if (n == 3)   chk("rgb_even_px0", rgb_of(0), 0);
            if (n == 4)   chk("rgb_odd_px1", rgb_of(0), 63);
            if (n == 642) chk("rgb_px639", rgb_of(0), 63);
            if (n == 643) chk("rgb_px640_blank", rgb_of(0), 0);
            if (n == 658) chk("hsync_before", int'(hs[0]), 1);
            if (n == 659) chk("hsync_first_low", int'(hs[0]), 0);
            if (n == 754) chk("hsync_last_low", int'(hs[0]), 0);
            if (n == 755) chk("hsync_end", int'(hs[0]), 1);
            if (n == 799) begin
                chk("wrap0_H", int'(cH[0]), 799);
                chk("wrap0_V", int'(cV[0]), 0);
            end
            if (n == 800) begin
                chk("line1_H", int'(cH[0]), 0);
                chk("line1_V", int'(cV[0]), 1);
            end
            if (n == 8799) begin
                chk("wrap10_H", int'(cH[0]), 799);
                chk("wrap10_V", int'(cV[0]), 10);
            end
            if (n == 8800) begin
                chk("line11_H", int'(cH[0]), 0);
                chk("line11_V", int'(cV[0]), 11);
            end
            if (n == 5497) chk("held1_h697_blank", rgb_of(0), 0);
            if (n == 4901) chk("held1_visible", rgb_of(0), 63);
            if (n == 9500) chk("hsync_low_pre_rst", int'(hs[0]), 0);

            if (n == 1) chk("pd0_rgb_px0", rgb_of(1), 0);
            if (n == 2) chk("pd0_rgb_px1", rgb_of(1), 63);
            if (n == 20) chk("pd0_hsync_before", int'(hs[1]), 1);
            if (n == 21) chk("pd0_hsync_low", int'(hs[1]), 0);
            if (n == 5) chk("pd4_rgb_px0", rgb_of(3), 0);
            if (n == 6) chk("pd4_rgb_px1", rgb_of(3), 63);
            if (n == 24) chk("pd4_hsync_before", int'(hs[3]), 1);
            if (n == 25) chk("pd4_hsync_low", int'(hs[3]), 0);

            if (n == 239) begin
                chk("fs_before", int'(fs[2]), 0);
                chk("vblank_before", int'(vb[2]), 0);
            end
            if (n == 240) begin
                chk("fs_rise", int'(fs[2]), 1);
                chk("vblank_rise", int'(vb[2]), 1);
            end
            if (n == 241) begin
                chk("fs_one_cycle", int'(fs[2]), 0);
                chk("vblank_held", int'(vb[2]), 1);
            end
            if (n == 302) chk("vsync_before", int'(vs[2]), 1);
            if (n == 303) chk("vsync_first_low", int'(vs[2]), 0);
            if (n == 362) chk("vsync_last_low", int'(vs[2]), 0);
            if (n == 363) chk("vsync_end", int'(vs[2]), 1);
            if (n == 449) begin
                chk("fwrap_H", int'(cH[2]), 29);
                chk("fwrap_V", int'(cV[2]), 14);
                chk("vblank_last", int'(vb[2]), 1);
            end
            if (n == 450) begin
                chk("frame1_H", int'(cH[2]), 0);
                chk("frame1_V", int'(cV[2]), 0);
                chk("vblank_fall", int'(vb[2]), 0);
            end
            if (n == 5228) chk("held1_vblank_rgb", rgb_of(2), 0);
            if (n > 0 && fs[2] === 1'b1) begin
                if (last_fs >= 0) chk("fs_period", n - last_fs, 450);
                last_fs = n;
            end
        end else begin
            if (n == 0) begin
                chk("midrst_hsync", int'(hs[0]), 1);
                chk("midrst_H", int'(cH[0]), 0);
                chk("midrst_rgb", rgb_of(0), 0);
            end
            if (n <= 658 && hs[0] !== 1'b1) lows++;
            if (n == 658) chk("midrst_no_hsync", lows, 0);
            if (n == 659) chk("midrst_hsync_low", int'(hs[0]), 0);
        end
    end

endmodule

`default_nettype wire
